// File: rtl/data_mem_responder.sv
// Purpose : multi-cycle load/store responder for the RV64 datapath, with byte/half/word/double
//           lane selection and sign/zero extension.
// Latency : request in cycle 0, response (DONE) in cycle LATENCY, next request no earlier than LATENCY+1.
// Backpressure: 'stall' freezes the core from the request cycle until DONE; requests in BUSY/DONE are ignored.
// Ports   : clk, reset (async, active-high), memread/memwrite (request strobes), funct3 (size/sign),
//           addr (byte address), wdata (store data), stall (hold core), rdata/rvalid (load response),
//           err (misaligned or illegal access pulse).
module data_mem_responder #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               op_rd;
    logic               op_wr;
    logic [2:0]         f3_q;
    logic [DATA_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               req;
    assign req = memread | memwrite;

    // Stall is asserted in the request cycle itself so the core never advances past the access.
    assign stall = ~reset & (((state == IDLE) & req) | (state == BUSY));

    // Response source: with LATENCY==1 the response is formed straight from the request
    // inputs (IDLE -> DONE), otherwise from the values latched at request time.
    logic               s_rd;
    logic               s_wr;
    logic [2:0]         s_f3;
    logic [DATA_W-1:0]  s_addr;

    always_comb begin
        s_rd   = op_rd;
        s_wr   = op_wr;
        s_f3   = f3_q;
        s_addr = addr_q;
        if (state == IDLE) begin
            s_rd   = memread;
            s_wr   = memwrite;
            s_f3   = funct3;
            s_addr = addr;
        end
    end

    logic [IDX_W-1:0]   s_idx;
    logic [2:0]         s_lane;
    logic [DATA_W-1:0]  rd_word;
    logic [DATA_W-1:0]  shifted;

    assign s_idx   = s_addr[IDX_W+2:3];
    assign s_lane  = s_addr[2:0];
    assign rd_word = mem[s_idx];
    assign shifted = rd_word >> {s_lane, 3'b000};

    // Address bits above the word index are ignored so accesses wrap around the array.
    logic unused_addr_hi;
    assign unused_addr_hi = ^s_addr[DATA_W-1:IDX_W+3];

    logic misalign;
    logic illegal;
    logic s_err;

    always_comb begin
        misalign = 1'b0;
        case (s_f3[1:0])
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = s_lane[0];
            2'd2:    misalign = |s_lane[1:0];
            default: misalign = |s_lane;
        endcase
    end

    assign illegal = (s_rd & s_wr) | (s_rd & (s_f3 == 3'b111)) | (s_wr & s_f3[2]);
    assign s_err   = misalign | illegal;

    logic [DATA_W-1:0] load_val;

    always_comb begin
        load_val = '0;
        case (s_f3)
            3'b000:  load_val = {{(DATA_W-8){shifted[7]}},   shifted[7:0]};
            3'b001:  load_val = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = {{(DATA_W-32){shifted[31]}}, shifted[31:0]};
            3'b011:  load_val = shifted;
            3'b100:  load_val = {{(DATA_W-8){1'b0}},  shifted[7:0]};
            3'b101:  load_val = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            3'b110:  load_val = {{(DATA_W-32){1'b0}}, shifted[31:0]};
            default: load_val = '0;
        endcase
    end

    // Store path works only from latched values; it commits on the edge leaving DONE.
    logic [7:0]         size_mask;
    logic [7:0]         be;
    logic [DATA_W-1:0]  wdata_sh;
    logic [IDX_W-1:0]   st_idx;
    logic               wr_en;

    always_comb begin
        size_mask = 8'h00;
        case (f3_q[1:0])
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    assign be       = size_mask << addr_q[2:0];
    assign wdata_sh = wdata_q << {addr_q[2:0], 3'b000};
    assign st_idx   = addr_q[IDX_W+2:3];
    // 'err' is the registered DONE-cycle flag, so an erroneous store never writes.
    // Under reset the state is IDLE, which discards any pending store.
    assign wr_en    = (state == DONE) & op_wr & ~err;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) begin
                    mem[st_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            op_rd   <= 1'b0;
            op_wr   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            rvalid  <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rdata  <= '0;
                    rvalid <= 1'b0;
                    err    <= 1'b0;
                    if (req) begin
                        op_rd   <= memread;
                        op_wr   <= memwrite;
                        f3_q    <= funct3;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt     <= CNT_W'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state  <= DONE;
                            err    <= s_err;
                            rvalid <= s_rd & ~s_err;
                            rdata  <= (s_rd & ~s_err) ? load_val : '0;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt <= CNT_W'(1)) begin
                        state  <= DONE;
                        err    <= s_err;
                        rvalid <= s_rd & ~s_err;
                        rdata  <= (s_rd & ~s_err) ? load_val : '0;
                    end
                    cnt <= cnt - CNT_W'(1);
                end
                DONE: begin
                    state  <= IDLE;
                    rdata  <= '0;
                    rvalid <= 1'b0;
                    err    <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    rdata  <= '0;
                    rvalid <= 1'b0;
                    err    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose : exercises three responders (LATENCY 2, 1, 15) against a byte-level memory model.
// Latency : each access is checked cycle by cycle from request to DONE.
// Backpressure: stall is checked in every cycle of every access.
module tb_data_mem_responder;

    logic        clk;
    logic        rst  [3];
    logic        rd   [3];
    logic        wr   [3];
    logic [2:0]  f3   [3];
    logic [63:0] ad   [3];
    logic [63:0] wd   [3];
    logic        st   [3];
    logic [63:0] rdat [3];
    logic        rv   [3];
    logic        er   [3];

    int errors = 0;
    int checks = 0;
    logic [63:0] last_rdata;

    // Reference storage: one 256-word image per responder.
    logic [63:0] mm [3][256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(
            .DATA_W (64),
            .DEPTH  (256),
            .LATENCY(g == 0 ? 2 : (g == 1 ? 1 : 15))
        ) u_dut (
            .clk     (clk),
            .reset   (rst[g]),
            .memread (rd[g]),
            .memwrite(wr[g]),
            .funct3  (f3[g]),
            .addr    (ad[g]),
            .wdata   (wd[g]),
            .stall   (st[g]),
            .rdata   (rdat[g]),
            .rvalid  (rv[g]),
            .err     (er[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Access semantics from byte-level rules: size = 2^funct3[1:0], little-endian lanes.
    function automatic void model(input int k, input logic r, input logic w, input logic [2:0] f,
                                  input logic [63:0] a, input logic [63:0] d,
                                  output logic e, output logic v, output logic [63:0] x);
        int size = 1 << f[1:0];
        int lane = int'(a[2:0]);
        int idx  = int'(a[10:3]);
        logic [63:0] val;
        e = (r && w) || (r && f == 3'b111) || (w && f[2]) || ((a % 64'(size)) != 0);
        v = 1'b0;
        x = '0;
        if (!e && r) begin
            val = '0;
            for (int b = 0; b < size; b++) val[8*b +: 8] = mm[k][idx][8*(lane+b) +: 8];
            if (!f[2] && size < 8 && val[8*size-1])
                for (int b = size; b < 8; b++) val[8*b +: 8] = 8'hFF;
            v = 1'b1;
            x = val;
        end
        if (!e && w) begin
            for (int b = 0; b < size; b++) mm[k][idx][8*(lane+b) +: 8] = d[8*b +: 8];
        end
    endfunction

    task automatic clear_in(input int k);
        rd[k] = 1'b0; wr[k] = 1'b0; f3[k] = 3'b000; ad[k] = '0; wd[k] = '0;
    endtask

    task automatic idle(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            clear_in(k);
            #1;
            chk("idle_stall", 64'(st[k]), 64'd0);
            chk("idle_rvalid", 64'(rv[k]), 64'd0);
            chk("idle_err", 64'(er[k]), 64'd0);
        end
    endtask

    task automatic access(input int k, input logic r, input logic w, input logic [2:0] f,
                          input logic [63:0] a, input logic [63:0] d, input bit junk);
        logic e, v;
        logic [63:0] x;
        int L = lat_of(k);
        model(k, r, w, f, a, d, e, v, x);
        @(posedge clk); #1;
        rd[k] = r; wr[k] = w; f3[k] = f; ad[k] = a; wd[k] = d;
        #1;
        chk("req_stall", 64'(st[k]), 64'd1);
        chk("req_rvalid", 64'(rv[k]), 64'd0);
        chk("req_err", 64'(er[k]), 64'd0);
        for (int c = 1; c <= L; c++) begin
            @(posedge clk); #1;
            // Inputs are ignored after the request cycle; scramble them to prove it.
            rd[k] = 1'b0; wr[k] = 1'b0;
            ad[k] = {$urandom, $urandom}; wd[k] = {$urandom, $urandom}; f3[k] = 3'($urandom_range(0, 7));
            if (c == L && junk) begin
                rd[k] = 1'($urandom_range(0, 1)); wr[k] = ~rd[k];
            end
            #1;
            if (c < L) begin
                chk("busy_stall", 64'(st[k]), 64'd1);
                chk("busy_rvalid", 64'(rv[k]), 64'd0);
                chk("busy_err", 64'(er[k]), 64'd0);
            end else begin
                chk("done_stall", 64'(st[k]), 64'd0);
                chk("done_rvalid", 64'(rv[k]), 64'(v));
                chk("done_err", 64'(er[k]), 64'(e));
                chk("done_rdata", rdat[k], x);
                last_rdata = rdat[k];
            end
        end
    endtask

    // Store issued, then reset pulsed one cycle later (BUSY, or DONE when LATENCY==1).
    task automatic reset_mid(input int k, input logic [63:0] a, input logic [63:0] d);
        @(posedge clk); #1;
        rd[k] = 1'b0; wr[k] = 1'b1; f3[k] = 3'b011; ad[k] = a; wd[k] = d;
        @(posedge clk); #1;
        clear_in(k);
        rst[k] = 1'b1;
        #1;
        chk("rst_mid_stall", 64'(st[k]), 64'd0);
        chk("rst_mid_rvalid", 64'(rv[k]), 64'd0);
        chk("rst_mid_err", 64'(er[k]), 64'd0);
        @(posedge clk); #1;
        rst[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            clear_in(k);
        end
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++) begin
            chk("rst_stall", 64'(st[k]), 64'd0);
            chk("rst_rdata", rdat[k], 64'd0);
            chk("rst_rvalid", 64'(rv[k]), 64'd0);
            chk("rst_err", 64'(er[k]), 64'd0);
        end
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        for (int k = 0; k < 3; k++) begin
            idle(k, 4);
            for (int i = 0; i < 256; i++)
                access(k, 1'b0, 1'b1, 3'b011, 64'(i * 8), {$urandom, $urandom}, 1'b0);

            access(k, 1'b0, 1'b1, 3'b011, 64'h10, 64'h8877665544332211, 1'b0);
            access(k, 1'b1, 1'b0, 3'b011, 64'h10, 64'h0, 1'b0);
            chk("ld_sd_word", last_rdata, 64'h8877665544332211);
            access(k, 1'b0, 1'b1, 3'b000, 64'h13, 64'h00000000000000AB, 1'b0);
            access(k, 1'b1, 1'b0, 3'b000, 64'h13, 64'h0, 1'b0);
            chk("lb_sign", last_rdata, 64'hFFFFFFFFFFFFFFAB);
            access(k, 1'b1, 1'b0, 3'b100, 64'h13, 64'h0, 1'b0);
            chk("lbu_zero", last_rdata, 64'h00000000000000AB);
            access(k, 1'b1, 1'b0, 3'b011, 64'h10, 64'h0, 1'b0);
            chk("ld_after_sb", last_rdata, 64'h88776655AB332211);
            access(k, 1'b1, 1'b0, 3'b010, 64'h12, 64'h0, 1'b0);
            access(k, 1'b0, 1'b1, 3'b010, 64'h12, 64'h0, 1'b0);
            access(k, 1'b1, 1'b1, 3'b011, 64'h10, 64'h0, 1'b0);
            access(k, 1'b1, 1'b0, 3'b111, 64'h10, 64'h0, 1'b0);
            access(k, 1'b0, 1'b1, 3'b100, 64'h10, 64'h0, 1'b0);
            access(k, 1'b1, 1'b0, 3'b011, 64'h10, 64'h0, 1'b0);
            chk("ld_after_errs", last_rdata, 64'h88776655AB332211);
            reset_mid(k, 64'h10, 64'hDEADBEEFCAFEF00D);
            idle(k, 2);
            access(k, 1'b1, 1'b0, 3'b011, 64'h10, 64'h0, 1'b0);
            chk("ld_after_rst", last_rdata, 64'h88776655AB332211);

            for (int i = 0; i < 150; i++) begin
                int sel;
                logic r, w;
                logic [2:0] f;
                logic [63:0] a;
                sel = $urandom_range(0, 9);
                r = (sel <= 4) || (sel == 9);
                w = (sel >= 5);
                f = 3'($urandom_range(0, 7));
                a = {$urandom, $urandom};
                if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << f[1:0]) - 1);
                if ($urandom_range(0, 29) == 0) begin
                    reset_mid(k, a & ~64'h7, {$urandom, $urandom});
                end else begin
                    access(k, r, w, f, a, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
                end
            end
            idle(k, 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
